// File: rtl/external_memory_arbiter_if.sv
// Requester-side and memory-side signals of the external memory arbiter.
// master = requesters plus the memory model; slave = the arbiter.
interface external_memory_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata;
    logic        pause;
    logic        mem_control;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_read_mode;
    logic [2:0]  mem_write_mode;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        grant;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, pause, mem_control, mem_addr, mem_wdata,
               mem_read_mode, mem_write_mode, busy, grant
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, pause, mem_control, mem_addr, mem_wdata,
               mem_read_mode, mem_write_mode, busy, grant
    );
endinterface

// File: rtl/external_memory_arbiter.sv
// Round-robin arbiter sharing the processor's external memory port between two requesters.
// Isolated access acks PAUSE_CYCLES+ACCESS_CYCLES+1 cycles after the request is sampled.
module external_memory_arbiter #(
    parameter int unsigned PAUSE_CYCLES  = 2,
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter logic [2:0]  MODE_NONE     = 3'd0,
    parameter logic [2:0]  MODE_WORD     = 3'd2
) (
    input logic                      clk,
    input logic                      rst,
    external_memory_arbiter_if.slave bus
);

    if (PAUSE_CYCLES < 1 || PAUSE_CYCLES > 15) begin : g_bad_pause
        $error("PAUSE_CYCLES must be in 1..15");
    end
    if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access
        $error("ACCESS_CYCLES must be in 1..15");
    end

    localparam logic [3:0] PAUSE_LOAD  = 4'(PAUSE_CYCLES - 1);
    localparam logic [3:0] ACCESS_LOAD = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_ACCESS, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_ptr;
    logic        r_grant;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        r_ack0;
    logic        r_ack1;
    logic [31:0] r_rdata;
    logic        r_pause;
    logic        r_busy;
    logic        r_mem_control;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [2:0]  r_rmode;
    logic [2:0]  r_wmode;

    logic [1:0]  w_req;
    logic        w_latch;
    logic        w_sel;
    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_acc_we;
    logic [31:0] w_acc_addr;
    logic [31:0] w_acc_wdata;

    assign w_req = {bus.req1, bus.req0};

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_sel   = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_req != 2'b00) begin
                    w_latch = 1'b1;
                    w_sel   = w_req[r_ptr] ? r_ptr : ~r_ptr;
                    w_next  = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (r_cnt == 4'd0) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) w_next = S_DONE;
            end
            S_DONE: begin
                // Processor is still stopped, so a waiting peer goes straight to ACCESS.
                if (w_req[~r_grant]) begin
                    w_latch = 1'b1;
                    w_sel   = ~r_grant;
                    w_next  = S_ACCESS;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase

        w_we        = w_sel ? bus.we1    : bus.we0;
        w_addr      = w_sel ? bus.addr1  : bus.addr0;
        w_wdata     = w_sel ? bus.wdata1 : bus.wdata0;
        w_acc_we    = w_latch ? w_we    : r_we;
        w_acc_addr  = w_latch ? w_addr  : r_addr;
        w_acc_wdata = w_latch ? w_wdata : r_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= 4'd0;
            r_ptr         <= 1'b0;
            r_grant       <= 1'b0;
            r_we          <= 1'b0;
            r_addr        <= 32'd0;
            r_wdata       <= 32'd0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_rdata       <= 32'd0;
            r_pause       <= 1'b0;
            r_busy        <= 1'b0;
            r_mem_control <= 1'b0;
            r_mem_addr    <= 32'd0;
            r_mem_wdata   <= 32'd0;
            r_rmode       <= MODE_NONE;
            r_wmode       <= MODE_NONE;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= (w_next == S_PAUSE) ? PAUSE_LOAD : ACCESS_LOAD;
            end else if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_latch) begin
                r_grant <= w_sel;
                r_we    <= w_we;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
            end

            if (r_state == S_DONE) r_ptr <= ~r_grant;

            // Outputs are registered from the next state so they line up with it.
            r_pause       <= (w_next != S_IDLE);
            r_busy        <= (w_next != S_IDLE);
            r_mem_control <= (w_next == S_ACCESS);
            if (w_next == S_ACCESS) begin
                r_mem_addr  <= w_acc_addr;
                r_mem_wdata <= w_acc_wdata;
            end
            r_wmode <= (w_next == S_ACCESS &&  w_acc_we) ? MODE_WORD : MODE_NONE;
            r_rmode <= (w_next == S_ACCESS && !w_acc_we) ? MODE_WORD : MODE_NONE;
            r_ack0  <= (w_next == S_DONE) && !r_grant;
            r_ack1  <= (w_next == S_DONE) &&  r_grant;

            if (r_state == S_ACCESS && w_next == S_DONE && !r_we) begin
                r_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.ack0           = r_ack0;
    assign bus.ack1           = r_ack1;
    assign bus.rdata          = r_rdata;
    assign bus.pause          = r_pause;
    assign bus.busy           = r_busy;
    assign bus.grant          = r_grant;
    assign bus.mem_control    = r_mem_control;
    assign bus.mem_addr       = r_mem_addr;
    assign bus.mem_wdata      = r_mem_wdata;
    assign bus.mem_read_mode  = r_rmode;
    assign bus.mem_write_mode = r_wmode;

endmodule

// File: tb/tb_external_memory_arbiter.sv
// Bench for external_memory_arbiter: directed requests, ack scoreboard, word memory model.
module tb_external_memory_arbiter;

    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_WORD = 3'd2;

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];
    logic [31:0] mem_arr [0:255];

    external_memory_arbiter_if bus();

    external_memory_arbiter #(
        .PAUSE_CYCLES (2),
        .ACCESS_CYCLES(2),
        .MODE_NONE    (MODE_NONE),
        .MODE_WORD    (MODE_WORD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_control && bus.mem_write_mode == MODE_WORD)
            mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = (bus.mem_control && bus.mem_read_mode == MODE_WORD) ?
                           mem_arr[bus.mem_addr[9:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.ack0 || bus.ack1)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, bus.ack1, bus.ack0}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("ack_both", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
                chk("ack_port", {31'd0, bus.ack1}, {31'd0, e.port});
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_grant", {31'd0, bus.grant}, {31'd0, e.port});
                if (!e.we) chk("ack_rdata", bus.rdata, e.rdata);
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_req(input bit port, input bit v, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.req1 = v; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = v; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    task automatic push_exp(input bit port, input bit we, input logic [31:0] rd, input int c);
        exp_t e;
        e.port = port; e.we = we; e.rdata = rd; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic do_iso(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd);
        int n;
        n = cyc;
        set_req(port, 1'b1, we, addr, wdata);
        push_exp(port, we, exp_rd, n + 5);
        go_to(n + 1);
        chk("pause_rise", {31'd0, bus.pause}, 32'd1);
        chk("busy_rise", {31'd0, bus.busy}, 32'd1);
        chk("grant", {31'd0, bus.grant}, {31'd0, port});
        go_to(n + 2);
        chk("ctl_in_pause", {31'd0, bus.mem_control}, 32'd0);
        for (int k = 3; k <= 4; k++) begin
            go_to(n + k);
            chk("ctl_access", {31'd0, bus.mem_control}, 32'd1);
            chk("mem_addr", bus.mem_addr, addr);
            chk("wmode", {29'd0, bus.mem_write_mode}, {29'd0, we ? MODE_WORD : MODE_NONE});
            chk("rmode", {29'd0, bus.mem_read_mode}, {29'd0, we ? MODE_NONE : MODE_WORD});
            if (we) chk("mem_wdata", bus.mem_wdata, wdata);
        end
        go_to(n + 5);
        chk("ctl_done", {31'd0, bus.mem_control}, 32'd0);
        chk("pause_done", {31'd0, bus.pause}, 32'd1);
        set_req(port, 1'b0, 1'b0, 32'd0, 32'd0);
        go_to(n + 6);
        chk("pause_fall", {31'd0, bus.pause}, 32'd0);
        chk("busy_fall", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pause"}, {31'd0, bus.pause}, 32'd0);
        chk({tag, "_ctl"}, {31'd0, bus.mem_control}, 32'd0);
        chk({tag, "_ack"}, {30'd0, bus.ack1, bus.ack0}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_grant"}, {31'd0, bus.grant}, 32'd0);
        chk({tag, "_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_rdata"}, bus.rdata, 32'd0);
        chk({tag, "_modes"}, {26'd0, bus.mem_read_mode, bus.mem_write_mode},
            {26'd0, MODE_NONE, MODE_NONE});
    endtask

    initial begin
        int n;
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        go_to(3);
        chk_reset_vals("rst_init");
        rst = 1'b0;
        go_to(5);

        do_iso(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h0);
        go_to(cyc + 2);
        do_iso(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
        go_to(cyc + 3);
        chk("rdata_hold", bus.rdata, 32'hDEADBEEF);
        do_iso(1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 32'h0);
        chk("rdata_after_write", bus.rdata, 32'hDEADBEEF);

        // Reset in the middle of an access on port 1; no ack may follow.
        go_to(cyc + 2);
        n = cyc;
        set_req(1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        go_to(n + 3);
        chk("pre_rst_ctl", {31'd0, bus.mem_control}, 32'd1);
        #2 rst = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        #1 chk_reset_vals("rst_mid");
        go_to(n + 5);
        rst = 1'b0;
        go_to(n + 7);

        // Simultaneous requests: pointer reset to 0, so port 0 wins and port 1 follows.
        n = cyc;
        set_req(1'b0, 1'b1, 1'b1, 32'h108, 32'h0BADF00D);
        set_req(1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
        push_exp(1'b0, 1'b1, 32'h0, n + 5);
        push_exp(1'b1, 1'b0, 32'hCAFEF00D, n + 8);
        for (int k = 1; k <= 8; k++) begin
            go_to(n + k);
            chk("sim_pause_high", {31'd0, bus.pause}, 32'd1);
            if (k == 5) set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
            if (k == 6) chk("sim_second_addr", bus.mem_addr, 32'h104);
            if (k == 8) set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        go_to(n + 9);
        chk("sim_pause_fall", {31'd0, bus.pause}, 32'd0);

        // Both held high: service must alternate every transaction.
        go_to(cyc + 2);
        n = cyc;
        set_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
        set_req(1'b1, 1'b1, 1'b0, 32'h108, 32'h0);
        for (int k = 0; k < 6; k++)
            push_exp(k[0], 1'b0, k[0] ? 32'h0BADF00D : 32'hDEADBEEF, n + 5 + 3 * k);
        go_to(n + 20);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        go_to(n + 21);
        chk("fair_pause_fall", {31'd0, bus.pause}, 32'd0);

        // Request withdrawn right after the grant still completes exactly once.
        go_to(cyc + 2);
        n = cyc;
        set_req(1'b0, 1'b1, 1'b1, 32'h10C, 32'h55AA55AA);
        push_exp(1'b0, 1'b1, 32'h0, n + 5);
        go_to(n + 1);
        set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        go_to(n + 3);
        chk("drop_ctl", {31'd0, bus.mem_control}, 32'd1);
        chk("drop_wdata", bus.mem_wdata, 32'h55AA55AA);
        for (int k = 6; k <= 12; k++) begin
            go_to(n + k);
            chk("drop_idle", {31'd0, bus.busy}, 32'd0);
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
